// File: rtl/bus_sequencer_pkg.sv
// bus_sequencer shared types and encodings
// states, opcodes, B-bus selects, ALU ops
package bus_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_F1, ST_F2, ST_F3, ST_DEC,
    ST_L1, ST_L2, ST_L3,
    ST_S1, ST_S2, ST_S3,
    ST_X1, ST_M1, ST_J1,
    ST_HALT
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MOVE  = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JMPZ  = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] BSEL_NONE = 3'b000;
  localparam logic [2:0] BSEL_GP   = 3'b001;
  localparam logic [2:0] BSEL_PC   = 3'b010;
  localparam logic [2:0] BSEL_GP2  = 3'b011;
  localparam logic [2:0] BSEL_MDR  = 3'b100;
  localparam logic [2:0] BSEL_MAR  = 3'b101;
  localparam logic [2:0] BSEL_IR   = 3'b110;

  localparam logic [1:0] ALU_PASSB = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_SUB   = 2'b10;
  localparam logic [1:0] ALU_PASSA = 2'b11;

  function automatic logic is_wait(state_t s);
    return (s == ST_F2) || (s == ST_L2) ||
           (s == ST_S3);
  endfunction

endpackage

// File: rtl/bus_sequencer_mem_wait_timer.sv
// mem_wait_timer: 8-bit wait counter
// cleared outside wait states, expires at LIMIT
module mem_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIM = 8'(LIMIT);

  logic [7:0] cnt;

  // count waiting cycles, restart on clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == LIM);

endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: Moore control FSM for
// the 16-bit B-bus datapath
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] IR,
  input  logic              Z,
  input  logic              mem_ready,
  output logic [2:0]        B_sel,
  output logic [1:0]        alu_op,
  output logic              mar_we,
  output logic              mdr_we,
  output logic              ir_we,
  output logic              ac_we,
  output logic              gp_we,
  output logic              gp2_we,
  output logic              pc_we,
  output logic              pc_inc,
  output logic              z_we,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              halted,
  output logic              bus_err
);

  state_t     state;
  logic       err_q;
  logic       waiting;
  logic       expired;
  logic [3:0] opc;
  logic       rsel;
  logic       unused_ir;

  assign opc       = IR[DATA_W-1 -: 4];
  assign rsel      = IR[0];
  assign unused_ir = ^IR[DATA_W-5:1];
  assign waiting   = is_wait(state);

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!waiting),
    .en      (waiting && !mem_ready),
    .expired (expired)
  );

  // state sequencing and sticky bus error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_F1;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        ST_F1: state <= ST_F2;
        ST_F2: begin
          if (mem_ready) begin
            state <= ST_F3;
          end else if (expired) begin
            state <= ST_HALT;
            err_q <= 1'b1;
          end
        end
        ST_F3: state <= ST_DEC;
        ST_DEC: begin
          case (opc)
            OP_LOAD:  state <= ST_L1;
            OP_STORE: state <= ST_S1;
            OP_ADD:   state <= ST_X1;
            OP_SUB:   state <= ST_X1;
            OP_MOVE:  state <= ST_M1;
            OP_JMP:   state <= ST_J1;
            OP_JMPZ:
              state <= Z ? ST_J1 : ST_F1;
            OP_HALT:  state <= ST_HALT;
            default:  state <= ST_F1;
          endcase
        end
        ST_L1: state <= ST_L2;
        ST_L2: begin
          if (mem_ready) begin
            state <= ST_L3;
          end else if (expired) begin
            state <= ST_HALT;
            err_q <= 1'b1;
          end
        end
        ST_L3: state <= ST_F1;
        ST_S1: state <= ST_S2;
        ST_S2: state <= ST_S3;
        ST_S3: begin
          if (mem_ready) begin
            state <= ST_F1;
          end else if (expired) begin
            state <= ST_HALT;
            err_q <= 1'b1;
          end
        end
        ST_X1:   state <= ST_F1;
        ST_M1:   state <= ST_F1;
        ST_J1:   state <= ST_F1;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_F1;
      endcase
    end
  end

  logic [2:0] bsel_c;
  logic [1:0] alu_c;
  logic       mar_c, mdr_c, ir_c, ac_c;
  logic       gp_c, gp2_c, pcw_c, pci_c;
  logic       z_c, rd_c, wr_c, hlt_c;

  // per-state control word
  always_comb begin
    bsel_c = BSEL_NONE;
    alu_c  = ALU_PASSB;
    mar_c  = 1'b0;
    mdr_c  = 1'b0;
    ir_c   = 1'b0;
    ac_c   = 1'b0;
    gp_c   = 1'b0;
    gp2_c  = 1'b0;
    pcw_c  = 1'b0;
    pci_c  = 1'b0;
    z_c    = 1'b0;
    rd_c   = 1'b0;
    wr_c   = 1'b0;
    hlt_c  = 1'b0;
    unique case (state)
      ST_F1: begin
        bsel_c = BSEL_PC;
        mar_c  = 1'b1;
      end
      ST_F2, ST_L2: begin
        rd_c  = 1'b1;
        mdr_c = 1'b1;
      end
      ST_F3: begin
        bsel_c = BSEL_MDR;
        ir_c   = 1'b1;
        pci_c  = 1'b1;
      end
      ST_L1, ST_S1: begin
        bsel_c = BSEL_IR;
        mar_c  = 1'b1;
      end
      ST_L3: begin
        bsel_c = BSEL_MDR;
        ac_c   = 1'b1;
        z_c    = 1'b1;
      end
      ST_S2: begin
        alu_c = ALU_PASSA;
        mdr_c = 1'b1;
      end
      ST_S3: wr_c = 1'b1;
      ST_X1: begin
        bsel_c = rsel ? BSEL_GP2 : BSEL_GP;
        alu_c  = (opc == OP_ADD) ?
                 ALU_ADD : ALU_SUB;
        ac_c   = 1'b1;
        z_c    = 1'b1;
      end
      ST_M1: begin
        alu_c = ALU_PASSA;
        gp_c  = !rsel;
        gp2_c = rsel;
      end
      ST_J1: begin
        bsel_c = BSEL_IR;
        pcw_c  = 1'b1;
      end
      ST_HALT: hlt_c = 1'b1;
      default: ;
    endcase
  end

  // reset blanks the control word at once
  assign B_sel   = rst_n ? bsel_c : BSEL_NONE;
  assign alu_op  = rst_n ? alu_c : ALU_PASSB;
  assign mar_we  = rst_n & mar_c;
  assign mdr_we  = rst_n & mdr_c;
  assign ir_we   = rst_n & ir_c;
  assign ac_we   = rst_n & ac_c;
  assign gp_we   = rst_n & gp_c;
  assign gp2_we  = rst_n & gp2_c;
  assign pc_we   = rst_n & pcw_c;
  assign pc_inc  = rst_n & pci_c;
  assign z_we    = rst_n & z_c;
  assign mem_rd  = rst_n & rd_c;
  assign mem_wr  = rst_n & wr_c;
  assign halted  = rst_n & hlt_c;
  assign bus_err = rst_n & err_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed checks of
// the bus_sequencer control traces
module tb_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] IR = 16'h0000;
  logic        Z = 1'b0;
  logic        mem_ready = 1'b1;
  logic [2:0]  B_sel;
  logic [1:0]  alu_op;
  logic mar_we, mdr_we, ir_we, ac_we;
  logic gp_we, gp2_we, pc_we, pc_inc;
  logic z_we, mem_rd, mem_wr, halted, bus_err;

  int n_pass = 0;
  int n_total = 0;

  bus_sequencer #(
    .DATA_W (16),
    .MEM_TIMEOUT (255)
  ) dut (
    .clk (clk), .rst_n (rst_n), .IR (IR),
    .Z (Z), .mem_ready (mem_ready),
    .B_sel (B_sel), .alu_op (alu_op),
    .mar_we (mar_we), .mdr_we (mdr_we),
    .ir_we (ir_we), .ac_we (ac_we),
    .gp_we (gp_we), .gp2_we (gp2_we),
    .pc_we (pc_we), .pc_inc (pc_inc),
    .z_we (z_we), .mem_rd (mem_rd),
    .mem_wr (mem_wr), .halted (halted),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {B_sel, alu_op, mar_we, mdr_we,
                ir_we, ac_we, gp_we, gp2_we,
                pc_we, pc_inc, z_we, mem_rd,
                mem_wr, halted, bus_err};

  localparam logic [17:0] E_ZERO = 18'd0;
  localparam logic [17:0] E_F1 =
    {3'b010, 2'b00, 13'b1000000000000};
  localparam logic [17:0] E_F2 =
    {3'b000, 2'b00, 13'b0100000001000};
  localparam logic [17:0] E_F3 =
    {3'b100, 2'b00, 13'b0010000100000};
  localparam logic [17:0] E_DEC = 18'd0;
  localparam logic [17:0] E_L1 =
    {3'b110, 2'b00, 13'b1000000000000};
  localparam logic [17:0] E_L3 =
    {3'b100, 2'b00, 13'b0001000010000};
  localparam logic [17:0] E_S2 =
    {3'b000, 2'b11, 13'b0100000000000};
  localparam logic [17:0] E_S3 =
    {3'b000, 2'b00, 13'b0000000000100};
  localparam logic [17:0] E_ADD2 =
    {3'b011, 2'b01, 13'b0001000010000};
  localparam logic [17:0] E_SUB1 =
    {3'b001, 2'b10, 13'b0001000010000};
  localparam logic [17:0] E_MV2 =
    {3'b000, 2'b11, 13'b0000010000000};
  localparam logic [17:0] E_MV1 =
    {3'b000, 2'b11, 13'b0000100000000};
  localparam logic [17:0] E_J1 =
    {3'b110, 2'b00, 13'b0000001000000};
  localparam logic [17:0] E_HLT =
    {3'b000, 2'b00, 13'b0000000000010};
  localparam logic [17:0] E_HLTE =
    {3'b000, 2'b00, 13'b0000000000011};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #3;
    n_total++;
    if (obs !== E_ZERO)
      $display("FAIL reset_out got %b want %b",
               obs, E_ZERO);
    else n_pass++;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_nop_fetch;
    logic [17:0] ex [5];
    ex = '{E_F1, E_F2, E_F3, E_DEC, E_F1};
    IR = 16'h0000;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (obs !== ex[i])
        $display("FAIL nop c%0d got %b want %b",
                 i, obs, ex[i]);
      else n_pass++;
      if (i < 4) tick();
    end
  endtask

  task automatic test_load_wait;
    logic [17:0] ex [11];
    logic mr [11];
    ex = '{E_F1, E_F2, E_F3, E_DEC, E_L1,
           E_F2, E_F2, E_F2, E_F2, E_L3, E_F1};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    IR = 16'h1005;
    for (int i = 0; i < 11; i++) begin
      mem_ready = mr[i];
      n_total++;
      if (obs !== ex[i])
        $display("FAIL load c%0d got %b want %b",
                 i, obs, ex[i]);
      else n_pass++;
      if (i < 10) tick();
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_store;
    logic [17:0] ex [8];
    ex = '{E_F1, E_F2, E_F3, E_DEC, E_L1,
           E_S2, E_S3, E_F1};
    IR = 16'h2000;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (obs !== ex[i])
        $display("FAIL store c%0d got %b want %b",
                 i, obs, ex[i]);
      else n_pass++;
      if (i < 7) tick();
    end
  endtask

  task automatic test_alu;
    logic [15:0] irs [2];
    logic [17:0] x1 [2];
    irs = '{16'h3001, 16'h4000};
    x1 = '{E_ADD2, E_SUB1};
    mem_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      IR = irs[t];
      tick(); tick(); tick(); tick();
      n_total++;
      if (obs !== x1[t])
        $display("FAIL alu_x1 %h got %b want %b",
                 irs[t], obs, x1[t]);
      else n_pass++;
      tick();
      n_total++;
      if (obs !== E_F1)
        $display("FAIL alu_ret %h got %b want %b",
                 irs[t], obs, E_F1);
      else n_pass++;
    end
  endtask

  task automatic test_move_jmp;
    logic [15:0] irs [3];
    logic [17:0] ex [3];
    irs = '{16'h5001, 16'h5000, 16'h6042};
    ex = '{E_MV2, E_MV1, E_J1};
    mem_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      IR = irs[t];
      tick(); tick(); tick(); tick();
      n_total++;
      if (obs !== ex[t])
        $display("FAIL exec %h got %b want %b",
                 irs[t], obs, ex[t]);
      else n_pass++;
      tick();
      n_total++;
      if (obs !== E_F1)
        $display("FAIL exec_ret %h got %b want %b",
                 irs[t], obs, E_F1);
      else n_pass++;
    end
  endtask

  task automatic test_jmpz;
    IR = 16'h7010;
    mem_ready = 1'b1;
    Z = 1'b1;
    tick(); tick(); tick(); tick();
    n_total++;
    if (obs !== E_J1)
      $display("FAIL jmpz_taken got %b want %b",
               obs, E_J1);
    else n_pass++;
    tick();
    Z = 1'b0;
    tick(); tick(); tick(); tick();
    n_total++;
    if (obs !== E_F1)
      $display("FAIL jmpz_not got %b want %b",
               obs, E_F1);
    else n_pass++;
  endtask

  task automatic test_undef_op;
    IR = 16'hA123;
    mem_ready = 1'b1;
    tick(); tick(); tick();
    n_total++;
    if (obs !== E_DEC)
      $display("FAIL undef_dec got %b want %b",
               obs, E_DEC);
    else n_pass++;
    tick();
    n_total++;
    if (obs !== E_F1)
      $display("FAIL undef_ret got %b want %b",
               obs, E_F1);
    else n_pass++;
  endtask

  task automatic test_timeout_edge;
    int bad = 0;
    IR = 16'h0000;
    tick();
    for (int k = 0; k < 256; k++) begin
      mem_ready = (k == 255);
      if (obs !== E_F2) bad++;
      tick();
    end
    n_total++;
    if (bad != 0)
      $display("FAIL edge_hold got %0d want 0",
               bad);
    else n_pass++;
    mem_ready = 1'b1;
    n_total++;
    if (obs !== E_F3)
      $display("FAIL edge_f3 got %b want %b",
               obs, E_F3);
    else n_pass++;
    tick(); tick();
    n_total++;
    if (obs !== E_F1)
      $display("FAIL edge_ret got %b want %b",
               obs, E_F1);
    else n_pass++;
  endtask

  task automatic test_timeout;
    int bad = 0;
    tick();
    for (int k = 0; k < 256; k++) begin
      mem_ready = 1'b0;
      if (obs !== E_F2) bad++;
      tick();
    end
    n_total++;
    if (bad != 0)
      $display("FAIL to_hold got %0d want 0",
               bad);
    else n_pass++;
    n_total++;
    if (obs !== E_HLTE)
      $display("FAIL to_halt got %b want %b",
               obs, E_HLTE);
    else n_pass++;
    mem_ready = 1'b1;
    tick(); tick(); tick();
    n_total++;
    if (obs !== E_HLTE)
      $display("FAIL to_sticky got %b want %b",
               obs, E_HLTE);
    else n_pass++;
  endtask

  task automatic test_reset_mid_store;
    apply_reset();
    n_total++;
    if (obs !== E_F1)
      $display("FAIL rst_clear got %b want %b",
               obs, E_F1);
    else n_pass++;
    IR = 16'h2000;
    mem_ready = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    n_total++;
    if (obs !== E_S3)
      $display("FAIL s3_wait got %b want %b",
               obs, E_S3);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (obs !== E_ZERO)
      $display("FAIL async_rst got %b want %b",
               obs, E_ZERO);
    else n_pass++;
    #1 rst_n = 1'b1;
    #1;
    mem_ready = 1'b1;
    n_total++;
    if (obs !== E_F1)
      $display("FAIL rst_f1 got %b want %b",
               obs, E_F1);
    else n_pass++;
    tick();
    n_total++;
    if (obs !== E_F2)
      $display("FAIL rst_f2 got %b want %b",
               obs, E_F2);
    else n_pass++;
  endtask

  task automatic test_halt;
    int bad = 0;
    apply_reset();
    IR = 16'hF000;
    mem_ready = 1'b1;
    tick(); tick(); tick(); tick();
    n_total++;
    if (obs !== E_HLT)
      $display("FAIL halt_entry got %b want %b",
               obs, E_HLT);
    else n_pass++;
    for (int k = 0; k < 100; k++) begin
      mem_ready = k[0];
      Z = k[1];
      if (obs !== E_HLT) bad++;
      tick();
    end
    n_total++;
    if (bad != 0)
      $display("FAIL halt_stay got %0d want 0",
               bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nop_fetch();
    test_load_wait();
    test_store();
    test_alu();
    test_move_jmp();
    test_jmpz();
    test_undef_op();
    test_timeout_edge();
    test_timeout();
    test_reset_mid_store();
    test_halt();
    $display("%0d/%0d checks passed",
             n_pass, n_total);
    $finish;
  end

endmodule
